draw_rdbuf: RTL

DRAW_RDBUF -- requirements
Module: draw_rdbuf

---
 rtl/draw_rdbuf_pkg.sv | 13 +
 rtl/draw_rdbuf_fifo.sv | 99 +++++++++
 rtl/draw_rdbuf.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/draw_rdbuf_pkg.sv
// rtl/draw_rdbuf_pkg.sv - shared constants and FSM state encoding for the VRAM read buffer
package draw_rdbuf_pkg;

    localparam int DEF_DEPTH    = 512;
    localparam int DEF_ADR_STEP = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;

endpackage

// File: rtl/draw_rdbuf_fifo.sv
// rtl/draw_rdbuf_fifo.sv - 64-bit synchronous FIFO with registered read port and over/underflow pulses
module draw_rdbuf_fifo
    import draw_rdbuf_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  logic [63:0]   wr_data_i,
    input  logic          rd_en_i,
    output logic [63:0]   rd_data_o,
    output logic          rd_valid_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          over_o,
    output logic          under_o
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [63:0]   rd_data_q;
    logic          rd_valid_q;
    logic          over_q;
    logic          under_q;
    logic          wr_ok;
    logic          rd_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    // A write into a full FIFO or a pop from an empty one is refused outright.
    assign wr_ok = wr_en_i && !full_o && !flush_i;
    assign rd_ok = rd_en_i && !empty_o && !flush_i;

    // Occupancy: a simultaneous accepted write and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers, count, registered read data and the one-cycle error pulses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            over_q     <= 1'b0;
            under_q    <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            over_q     <= 1'b0;
            under_q    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            count_q    <= count_d;
            rd_valid_q <= rd_ok;
            over_q     <= wr_en_i && full_o;
            under_q    <= rd_en_i && empty_o;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign count_o    = count_q;
    assign over_o     = over_q;
    assign under_o    = under_q;

endmodule

// File: rtl/draw_rdbuf.sv
// rtl/draw_rdbuf.sv - VRAM burst reader with credit-limited requests feeding a pixel FIFO (STAT_RDCNT counter: DRAW_RDBUF_STAT_EN)
module draw_rdbuf
    import draw_rdbuf_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADR_STEP = DEF_ADR_STEP
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        INIT,
    input  logic        START,
    input  logic [31:0] START_ADR,
    input  logic [9:0]  RD_LEN,
    output logic        VRAM_RDREQ,
    output logic [31:0] VRAM_RDADR,
    input  logic        VRAM_RDACK,
    input  logic        VRAM_RDVALID,
    input  logic [63:0] VRAM_RDDATA,
    input  logic        BUF_RD,
    output logic [63:0] PIXEL_DATA,
    output logic        DATAVALID,
    output logic        EMPTY,
    output logic        FULL,
    output logic        BUSY,
    output logic        DONE,
    output logic        BUF_OVER,
    output logic        BUF_UNDER,
    output logic [31:0] STAT_RDCNT
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state_q,   state_d;
    logic [31:0]   adr_q,     adr_d;
    logic [9:0]    remain_q,  remain_d;
    logic [CW-1:0] outst_q,   outst_d;
    logic          discard_q, discard_d;
    logic          done_q,    done_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_wr;
    logic [CW:0]   inflight;
    logic          credit_ok;
    logic          ack;
    logic          ret;

    // Words already buffered plus words still in flight must never exceed the FIFO,
    // so an issued request always has a slot waiting for its return.
    assign inflight  = {1'b0, fifo_count} + {1'b0, outst_q};
    assign credit_ok = (inflight < (CW+1)'(DEPTH));

    assign VRAM_RDREQ = (state_q == ST_ISSUE) && (remain_q != '0) && credit_ok && !INIT;
    assign VRAM_RDADR = adr_q;

    assign ack = VRAM_RDREQ && VRAM_RDACK;
    assign ret = VRAM_RDVALID && (outst_q != '0);

    // Returns belonging to an aborted burst drain the credit count but never reach the FIFO.
    assign fifo_wr = VRAM_RDVALID && !discard_q && !INIT;

    // Next-state logic for the burst FSM, address, remaining length and credits.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        remain_d  = remain_q;
        outst_d   = outst_q + CW'(ack) - CW'(ret);
        discard_d = discard_q;
        done_d    = 1'b0;

        if (discard_q && outst_d == '0) begin
            discard_d = 1'b0;
        end

        if (INIT) begin
            state_d   = ST_IDLE;
            remain_d  = '0;
            discard_d = (outst_d != '0);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START && outst_q == '0) begin
                        adr_d    = START_ADR;
                        remain_d = RD_LEN;
                        state_d  = (RD_LEN == '0) ? ST_WAIT : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ack) begin
                        adr_d    = adr_q + 32'(ADR_STEP);
                        remain_d = remain_q - 10'd1;
                        if (remain_q == 10'd1) begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (outst_d == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Burst control registers.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            remain_q  <= '0;
            outst_q   <= '0;
            discard_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            remain_q  <= remain_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            done_q    <= done_d;
        end
    end

    assign DONE = done_q;
    assign BUSY = (state_q != ST_IDLE) || (outst_q != '0);
    assign FULL = fifo_full;

    draw_rdbuf_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_n_i    (RST_X),
        .flush_i    (INIT),
        .wr_en_i    (fifo_wr),
        .wr_data_i  (VRAM_RDDATA),
        .rd_en_i    (BUF_RD),
        .rd_data_o  (PIXEL_DATA),
        .rd_valid_o (DATAVALID),
        .count_o    (fifo_count),
        .empty_o    (EMPTY),
        .full_o     (fifo_full),
        .over_o     (BUF_OVER),
        .under_o    (BUF_UNDER)
    );

`ifdef DRAW_RDBUF_STAT_EN
    logic [31:0] stat_q;

    // Counts words actually written into the FIFO; wraps naturally at 2^32.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            stat_q <= '0;
        end else if (INIT) begin
            stat_q <= '0;
        end else if (fifo_wr && !fifo_full) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign STAT_RDCNT = stat_q;
`else
    assign STAT_RDCNT = 32'd0;
`endif

endmodule
